slowram_arbiter: RTL
====================

# slowram_arbiter

Arbitrates the 128 KB 1 MHz slow RAM (banks E0/E1) among three requesters: the video fetcher, a posted-write FIFO carrying shadowed CPU writes from banks 00/01, and direct CPU accesses to E0/E1. It generates one access slot per SLOT_DIV clk_sys cycles, so slow RAM runs at the 1 MHz rate. It asserts a stall toward the CPU when shadow traffic backs up. It sits between the core bus decode and the slowram instance and replaces the direct CPU-to-slowram connection.

## Interface
- SLOT_DIV, 14: clk_sys cycles per slow RAM slot (≥3).
- FIFO_DEPTH, 4: shadow-write FIFO entries (power of two, ≥2).
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video fetch pending (level).
- vid_addr  in  17  {bank[0], addr} for the video fetch.
- vid_data  out  8  video read data.
- vid_valid  out  1  one-cycle pulse; vid_data valid.
- shd_wr  in  1  one-cycle pulse; a shadowed write was seen in bank 00/01.
- shd_addr  in  17  shadow write address.
- shd_data  in  8  shadow write data.
- cpu_req  in  1  direct E0/E1 access pending (level, held until cpu_ack).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  17  direct access address.
- cpu_din  in  8  direct write data.
- cpu_dout  out  8  direct read data.
- cpu_ack  out  1  one-cycle pulse; direct access complete.
- cpu_stall  out  1  registered; high while FIFO count ≥ FIFO_DEPTH-1.
- ovf  out  1  sticky; a shadow write was dropped.
- ram_addr  out  17  slow RAM address.
- ram_din  out  8  slow RAM write data.
- ram_dout  in  8  slow RAM read data (one-cycle registered latency).
- ram_ce  out  1  slow RAM enable.
- ram_we  out  1  slow RAM write strobe.

## Operation
- A slot counter `sc` counts 0..SLOT_DIV-1 and then wraps to 0. Grant is decided only when sc==0.
- States:
  - IDLE: when sc==0 and any request is pending, latch the winner and go to ACC.
  - ACC: drive ram_ce=1 and ram_addr. ram_we=1 for a shadow or CPU write. Go to RESP.
  - RESP: for a read, capture ram_dout into vid_data or cpu_dout. Pulse vid_valid or cpu_ack as applicable, then return to IDLE.
- Fixed priority: video, then FIFO non-empty, then cpu_req.
  - Because the FIFO outranks the CPU, a direct CPU access is granted only when the FIFO is empty. This guarantees write-then-read ordering to shadowed locations.
- A shadow grant pops the FIFO head in the ACC cycle. It produces no ack.
- FIFO push:
  - On shd_wr, push {shd_addr, shd_data}.
  - If count==FIFO_DEPTH and no pop occurs in the same cycle, drop the write and set ovf.
  - A push and a pop in the same cycle leave count unchanged.
- cpu_stall is the registered compare of count ≥ FIFO_DEPTH-1. The core must stop issuing shadowed writes while it is high; this leaves one entry of slack for a write already in flight.
- ram_ce and ram_we are zero outside ACC. ram_addr and ram_din hold their last values.
- cpu_req must deassert by the cycle after cpu_ack. The next grant decision cannot occur until SLOT_DIV-2 cycles later.

## Timing
- Reset values:
  - State IDLE, sc=0, FIFO empty.
  - All outputs 0: vid_data, cpu_dout, vid_valid, cpu_ack, cpu_stall, ovf, ram_addr, ram_din, ram_ce, ram_we.
- Slot at cycle T (sc==0 with a request pending):
  - ACC at T+1.
  - RESP and ack/valid pulse at T+2; read data is valid in that same cycle.
- Worst-case latency for a CPU access with the FIFO full and video idle is (FIFO_DEPTH+1)·SLOT_DIV+2 cycles.
- A request arriving at sc==1 waits SLOT_DIV-1 cycles for the next slot.
- Reset asserted mid-access aborts the access: no ack, no valid, no pop completion beyond the ACC cycle already taken.
- ovf clears only on reset.

## Test plan
- Reset, then cpu_req read at addr 0x0_0400 (RAM preloaded 0x5A): ram_ce pulses once at the first sc==0 plus 1; cpu_ack and cpu_dout=0x5A arrive two cycles after the grant.
- Three shd_wr pulses (0x0_2000←0x11, 0x0_2001←0x22, 0x0_2002←0x33), then a CPU read of 0x0_2002: three writes are issued in three consecutive slots, then the CPU read returns 0x33 in the fourth slot.
- vid_req and cpu_req both held: video is granted every slot and the CPU starves. Drop vid_req: the CPU is granted at the next slot.
- Five shd_wr pulses in back-to-back cycles with FIFO_DEPTH=4 and no slot boundary: cpu_stall rises after the third push, the fifth write is dropped, and ovf=1.
- A shd_wr while full, coinciding with a pop at ACC: the write is accepted, count stays 4, and ovf stays 0.
- reset_n asserted during ACC of a CPU read: outputs are 0 immediately, no cpu_ack follows, and after release the first grant occurs at the next sc==0.

Source files
------------

// File: rtl/slowram_arbiter.sv
// Slow RAM (E0/E1) arbiter: one access slot per SLOT_DIV clocks shared
// by video fetch, a posted shadow-write FIFO and direct CPU accesses.
module slowram_arbiter #(
   parameter int SLOT_DIV   = 14,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        vid_req,
   input  logic [16:0] vid_addr,
   output logic [7:0]  vid_data,
   output logic        vid_valid,
   input  logic        shd_wr,
   input  logic [16:0] shd_addr,
   input  logic [7:0]  shd_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [16:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   output logic        cpu_stall,
   output logic        ovf,
   output logic [16:0] ram_addr,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout,
   output logic        ram_ce,
   output logic        ram_we
);

   localparam int SCW = $clog2(SLOT_DIV);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] SRC_VID = 2'd0;
   localparam logic [1:0] SRC_SHD = 2'd1;
   localparam logic [1:0] SRC_CPU = 2'd2;

   logic [SCW-1:0] sc;
   logic [1:0]     state;
   logic [1:0]     src;
   logic           we_q;
   logic [7:0]     vid_q;
   logic [7:0]     cpu_q;

   logic [24:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count;

   logic fifo_ne;
   logic full;
   logic grant;
   logic sel_vid;
   logic sel_shd;
   logic sel_cpu;
   logic pop;
   logic push;
   logic resp;

   assign fifo_ne = (count != '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign sel_vid = vid_req;
   assign sel_shd = !vid_req && fifo_ne;
   assign sel_cpu = !vid_req && !fifo_ne && cpu_req;
   assign grant   = (state == S_IDLE) && (sc == '0)
                  && (sel_vid || sel_shd || sel_cpu);
   assign pop     = (state == S_ACC) && (src == SRC_SHD);
   // A full FIFO still accepts a write in the cycle its head is popped.
   assign push    = shd_wr && (!full || pop);
   assign resp    = (state == S_RESP);

   assign ram_ce    = (state == S_ACC);
   assign ram_we    = ram_ce && we_q;
   assign vid_valid = resp && (src == SRC_VID);
   assign cpu_ack   = resp && (src == SRC_CPU);
   // Read data is passed straight through in the response cycle.
   assign vid_data  = vid_valid ? ram_dout : vid_q;
   assign cpu_dout  = (cpu_ack && !we_q) ? ram_dout : cpu_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sc <= '0;
      end else if (sc == SCW'(SLOT_DIV - 1)) begin
         sc <= '0;
      end else begin
         sc <= sc + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         src      <= SRC_VID;
         we_q     <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (grant) begin
                  state <= S_ACC;
                  unique case (1'b1)
                     sel_vid: begin
                        src      <= SRC_VID;
                        we_q     <= 1'b0;
                        ram_addr <= vid_addr;
                     end
                     sel_shd: begin
                        src      <= SRC_SHD;
                        we_q     <= 1'b1;
                        ram_addr <= fifo_mem[head][24:8];
                        ram_din  <= fifo_mem[head][7:0];
                     end
                     default: begin
                        src      <= SRC_CPU;
                        we_q     <= cpu_we;
                        ram_addr <= cpu_addr;
                        if (cpu_we) ram_din <= cpu_din;
                     end
                  endcase
               end
            end
            S_ACC:   state <= S_RESP;
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         vid_q <= '0;
         cpu_q <= '0;
      end else begin
         if (vid_valid) vid_q <= ram_dout;
         if (cpu_ack && !we_q) cpu_q <= ram_dout;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem[tail] <= {shd_addr, shd_data};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         cpu_stall <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (shd_wr && !push) ovf <= 1'b1;
         cpu_stall <= (count >= CW'(FIFO_DEPTH - 1));
      end
   end

endmodule
